axis_header_inserter: RTL and testbench
=======================================

# axis_header_inserter

Prepends a variable-length header (1 to DATA_WIDTH/8 bytes) to each AXI4-Stream packet and repacks the bytes so the output carries no gaps. It sits directly upstream of the `DataInserterStream` FIFO stage, driving that stage's `s_axis_*` port. The last output beat's `tkeep` is MSB-justified. Byte order is big-endian: the MSB byte of `tdata` is the first byte on the wire.

## Interface
- `DATA_WIDTH`, default 32: bus width in bits. Must be a multiple of 8. N = DATA_WIDTH/8 bytes per beat.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `hdr_tdata` in DATA_WIDTH: header word; valid bytes are LSB-justified.
- `hdr_tkeep` in N: contiguous LSB-justified mask; H = popcount, 1..N. Zero is illegal.
- `hdr_tvalid` in 1 / `hdr_tready` out 1: header handshake.
- `s_axis_tdata` in DATA_WIDTH: payload data.
- `s_axis_tkeep` in N: all ones except on the last beat, which is MSB-justified; L = popcount, 1..N.
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1 / `s_axis_tlast` in 1: payload handshake and end of packet.
- `m_axis_tdata` out DATA_WIDTH: output data; invalid bytes are driven 0.
- `m_axis_tkeep` out N: output byte mask, MSB-justified.
- `m_axis_tvalid` out 1 / `m_axis_tready` in 1 / `m_axis_tlast` out 1: output handshake and end of packet.

## Operation
- State machine: IDLE, BODY, TAIL. Registers:
  - carry: up to N bytes;
  - cnt: carry byte count, 0..N;
  - output register: `m_axis_*`.
- out_free = !m_axis_tvalid || m_axis_tready.
- IDLE:
  - `hdr_tready` = 1, `s_axis_tready` = 0.
  - On header handshake: carry ← the H header bytes, cnt ← H, go to BODY.
- BODY:
  - `s_axis_tready` = out_free, `hdr_tready` = 0.
  - Per payload handshake, form the byte stream {carry[cnt bytes], payload[K bytes]}, where K = N, or L on the last beat.
  - Non-last beat: output ← first N bytes, keep all ones, tlast 0. carry ← last H payload bytes; cnt stays H.
  - Last beat, H+L ≤ N: output ← H+L bytes, keep = top H+L bits, tlast 1. Go to IDLE.
  - Last beat, H+L > N: output ← N bytes, tlast 0. carry ← remaining H+L−N bytes, cnt ← H+L−N. Go to TAIL.
- TAIL:
  - Both readies are 0.
  - When out_free: output ← carry, keep = top cnt bits, tlast 1. Go to IDLE.
- Payload presented while in IDLE is stalled (`s_axis_tready` = 0) until a header is accepted.
- `m_axis_*` holds its value while `m_axis_tvalid` && !`m_axis_tready`.
- When out_free and no beat is being loaded, `m_axis_tvalid` is cleared.

## Timing
- Reset values:
  - state = IDLE;
  - carry = 0, cnt = 0;
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tkeep` = 0;
  - `hdr_tready` = 0 and `s_axis_tready` = 0 while `rst` is high.
- Latency: each output beat is valid the cycle after its payload handshake, or the cycle after entering TAIL.
- Throughput: one beat per cycle in BODY under continuous `m_axis_tready`.
- Packet overhead:
  - H+L ≤ N: one idle cycle between packets (header acceptance).
  - H+L > N: one additional TAIL cycle.
- Readies are combinational from state and out_free. `m_axis_*` are registered.
- Reset asserted mid-packet: all registers clear immediately and the partial packet is discarded. After reset release, the first handshake accepted is a header.
- H = N: the first output beat is exactly the header word.

## Structure
- Package `axis_hdr_pkg`:
  - state enum;
  - function keep→count (popcount of a contiguous mask);
  - function count→MSB-justified keep.
- Sub-module `axis_byte_merge`: combinational. Inputs: carry, cnt, payload, K. Outputs: the first N bytes, the residue bytes, and the residue count.
- FSM and output register live in the top module.

## Test plan
- DATA_WIDTH=32, H=3 header 0x00AABBCC/0111, payload 0x11223344/1111 then 0x55667788/1100 last → 0xAABBCC11/1111, then 0x22334455/1111, then 0x66000000/1000 last.
- H=1 header 0x000000EE/0001, single payload 0x11223344/1110 last → one beat 0xEE112233/1111 last.
- H=4 header 0xDEADBEEF/1111, payload 0x01020304/1000 last → 0xDEADBEEF/1111, then 0x01000000/1000 last.
- First scenario with `m_axis_tready` toggled pseudo-randomly → same 3 beats. Data is stable whenever `m_axis_tvalid` && !`m_axis_tready`. No beat is lost or duplicated.
- `s_axis_tvalid` high 5 cycles before `hdr_tvalid` → `s_axis_tready` = 0 throughout and no output. Normal packet output follows the header handshake.
- `rst` pulsed in BODY after one output beat → all outputs 0 the same cycle, state IDLE. The following packet (H=2) is output correctly.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// ---------------------------------------------------------------------------
// axis_hdr_pkg: shared FSM state type and keep-mask helpers for the inserter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axis_hdr_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) c++;
    end
    return c;
  endfunction

  // Top `count` bits of an n-bit mask, i.e. MSB-justified keep
  function automatic logic [MAX_BYTES-1:0] count_to_keep(input int count, input int n);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < n) && (i >= n - count)) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_byte_merge.sv
// ---------------------------------------------------------------------------
// axis_byte_merge: joins cnt carry bytes with k payload bytes, MSB-first
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]                carry,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]    cnt,
  input  logic [DATA_WIDTH-1:0]                payload,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]    k,
  output logic [DATA_WIDTH-1:0]                first_bytes,
  output logic [DATA_WIDTH-1:0]                residue,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]    residue_cnt
);

  localparam int N  = DATA_WIDTH / 8;
  localparam int CW = $clog2(N + 1);

  logic [DATA_WIDTH-1:0]   carry_m;
  logic [DATA_WIDTH-1:0]   payload_m;
  logic [2*DATA_WIDTH-1:0] merged;
  logic [CW:0]             total;

  always_comb begin
    carry_m   = '0;
    payload_m = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(cnt)) carry_m[DATA_WIDTH-8*(i+1) +: 8] = carry[DATA_WIDTH-8*(i+1) +: 8];
      if (i < int'(k))   payload_m[DATA_WIDTH-8*(i+1) +: 8] = payload[DATA_WIDTH-8*(i+1) +: 8];
    end
    // Payload slides right behind the carry bytes; the lower half is what overflows
    merged = {carry_m, {DATA_WIDTH{1'b0}}} |
             ({payload_m, {DATA_WIDTH{1'b0}}} >> (8 * int'(cnt)));
    total  = {1'b0, cnt} + {1'b0, k};
    residue_cnt = (total > (CW+1)'(N)) ? CW'(total - (CW+1)'(N)) : '0;
  end

  assign first_bytes = merged[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign residue     = merged[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/axis_header_inserter.sv
// ---------------------------------------------------------------------------
// axis_header_inserter: prepends a 1..N byte header, repacks gap-free
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_header_inserter
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   hdr_tdata,
  input  logic [DATA_WIDTH/8-1:0] hdr_tkeep,
  input  logic                    hdr_tvalid,
  output logic                    hdr_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int N  = DATA_WIDTH / 8;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_FULL = CW'(N);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] carry_q, carry_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [N-1:0]          m_tkeep_q, m_tkeep_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;

  logic                  out_free;
  logic [CW-1:0]         hdr_cnt;
  logic [CW-1:0]         pay_cnt;
  logic [CW:0]           total;
  logic [DATA_WIDTH-1:0] merge_first;
  logic [DATA_WIDTH-1:0] merge_residue;
  logic [CW-1:0]         merge_residue_cnt;

  assign out_free = !m_tvalid_q || m_axis_tready;
  assign hdr_cnt  = CW'(keep_to_count(MAX_BYTES'(hdr_tkeep)));
  assign pay_cnt  = s_axis_tlast ? CW'(keep_to_count(MAX_BYTES'(s_axis_tkeep))) : C_FULL;
  assign total    = {1'b0, cnt_q} + {1'b0, pay_cnt};

  axis_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .carry       (carry_q),
    .cnt         (cnt_q),
    .payload     (s_axis_tdata),
    .k           (pay_cnt),
    .first_bytes (merge_first),
    .residue     (merge_residue),
    .residue_cnt (merge_residue_cnt)
  );

  always_comb begin
    state_d       = state_q;
    carry_d       = carry_q;
    cnt_d         = cnt_q;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tlast_d     = m_tlast_q;
    m_tvalid_d    = out_free ? 1'b0 : m_tvalid_q;
    hdr_tready    = 1'b0;
    s_axis_tready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hdr_tready = !rst;
        if (hdr_tvalid) begin
          // Header arrives LSB-justified; carry is kept MSB-first
          carry_d = hdr_tdata << (8 * (N - int'(hdr_cnt)));
          cnt_d   = hdr_cnt;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        s_axis_tready = out_free && !rst;
        if (s_axis_tvalid && out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = merge_first;
          if (!s_axis_tlast) begin
            m_tkeep_d = '1;
            m_tlast_d = 1'b0;
            carry_d   = merge_residue;
          end else if (total <= (CW+1)'(N)) begin
            m_tkeep_d = N'(count_to_keep(int'(total), N));
            m_tlast_d = 1'b1;
            carry_d   = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            m_tkeep_d = '1;
            m_tlast_d = 1'b0;
            carry_d   = merge_residue;
            cnt_d     = merge_residue_cnt;
            state_d   = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = carry_q;
          m_tkeep_d  = N'(count_to_keep(int'(cnt_q), N));
          m_tlast_d  = 1'b1;
          carry_d    = '0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      carry_q    <= '0;
      cnt_q      <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_header_inserter.sv
// ---------------------------------------------------------------------------
// tb_axis_header_inserter: directed self-checking bench, 32-bit bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_header_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hdr_tdata;
  logic [3:0]  hdr_tkeep;
  logic        hdr_tvalid;
  logic        hdr_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t got[$];
  beat_t exp[$];
  int    checks = 0;
  int    passes = 0;
  logic  rand_ready = 1'b0;
  logic  hold_pending = 1'b0;
  logic [36:0] hold_beat = '0;

  axis_header_inserter #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .hdr_tdata     (hdr_tdata),
    .hdr_tkeep     (hdr_tkeep),
    .hdr_tvalid    (hdr_tvalid),
    .hdr_tready    (hdr_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  end

  // Output monitor: captures accepted beats and checks hold-while-stalled
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) chk("hold", {27'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {27'd0, hold_beat});
      if (m_axis_tvalid && m_axis_tready)
        got.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
      hold_pending = m_axis_tvalid && !m_axis_tready;
      hold_beat    = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
    logic ok;
    ok = 1'b0;
    hdr_tdata  = d;
    hdr_tkeep  = k;
    hdr_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (hdr_tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    hdr_tvalid = 1'b0;
    chk("hdr_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
    logic ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    chk("beat_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic add_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp.push_back('{d: d, k: k, l: l});
  endtask

  task automatic check_pkt(input string tag);
    int n;
    n = 0;
    while (got.size() < exp.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk($sformatf("%s_count", tag), 64'(got.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) begin
        chk($sformatf("%s_data%0d", tag, i), {32'd0, got[i].d}, {32'd0, exp[i].d});
        chk($sformatf("%s_keep%0d", tag, i), {60'd0, got[i].k}, {60'd0, exp[i].k});
        chk($sformatf("%s_last%0d", tag, i), {63'd0, got[i].l}, {63'd0, exp[i].l});
      end
    end
    got.delete();
    exp.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hdr_tdata = '0; hdr_tkeep = '0; hdr_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("rst_tkeep", {60'd0, m_axis_tkeep}, 64'd0);
    chk("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    chk("rst_hdr_tready", {63'd0, hdr_tready}, 64'd0);
    chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("idle_hdr_tready", {63'd0, hdr_tready}, 64'd1);
    chk("idle_s_tready", {63'd0, s_axis_tready}, 64'd0);
    @(posedge clk);
    #1;

    // H=3, two payload beats, spills into TAIL
    send_hdr(32'h00AABBCC, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    add_exp(32'hAABBCC11, 4'b1111, 1'b0);
    add_exp(32'h22334455, 4'b1111, 1'b0);
    add_exp(32'h66000000, 4'b1000, 1'b1);
    check_pkt("h3");

    // H=1, single short last beat fits in one output beat
    send_hdr(32'h000000EE, 4'b0001);
    send_beat(32'h11223344, 4'b1110, 1'b1);
    chk("h1_latency_valid", {63'd0, m_axis_tvalid}, 64'd1);
    add_exp(32'hEE112233, 4'b1111, 1'b1);
    check_pkt("h1");

    // H=N: first beat is the header word verbatim
    send_hdr(32'hDEADBEEF, 4'b1111);
    send_beat(32'h01020304, 4'b1000, 1'b1);
    add_exp(32'hDEADBEEF, 4'b1111, 1'b0);
    add_exp(32'h01000000, 4'b1000, 1'b1);
    check_pkt("h4");

    // Backpressure on the output
    rand_ready = 1'b1;
    send_hdr(32'h00AABBCC, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    add_exp(32'hAABBCC11, 4'b1111, 1'b0);
    add_exp(32'h22334455, 4'b1111, 1'b0);
    add_exp(32'h66000000, 4'b1000, 1'b1);
    check_pkt("bp");
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_axis_tready = 1'b1;

    // Payload offered before any header must stall
    s_axis_tdata  = 32'hC1C2C3C4;
    s_axis_tkeep  = 4'b1100;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("early_s_tready%0d", i), {63'd0, s_axis_tready}, 64'd0);
      chk($sformatf("early_m_tvalid%0d", i), {63'd0, m_axis_tvalid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send_hdr(32'h0000A1A2, 4'b0011);
    send_beat(32'hC1C2C3C4, 4'b1100, 1'b1);
    add_exp(32'hA1A2C1C2, 4'b1111, 1'b1);
    check_pkt("early");

    // Reset in the middle of a packet
    send_hdr(32'h00112233, 4'b0111);
    send_beat(32'h44556677, 4'b1111, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mid_rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("mid_rst_tkeep", {60'd0, m_axis_tkeep}, 64'd0);
    chk("mid_rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    chk("mid_rst_hdr_tready", {63'd0, hdr_tready}, 64'd0);
    chk("mid_rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("mid_rst_beats", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("mid_rst_beat0", {32'd0, got[0].d}, {32'd0, 32'h11223344});
    got.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hdr_tready", {63'd0, hdr_tready}, 64'd1);
    chk("post_rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    @(posedge clk);
    #1;
    send_hdr(32'h0000ABCD, 4'b0011);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1110, 1'b1);
    add_exp(32'hABCD0102, 4'b1111, 1'b0);
    add_exp(32'h03040506, 4'b1111, 1'b0);
    add_exp(32'h07000000, 4'b1000, 1'b1);
    check_pkt("h2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
